adc_avg_filter: RTL and testbench

Post-processing stage that sits directly downstream of the ADS1115 I2C driver and consumes its 16-bit signed sample stream (`o_data`/`o_valid`). It keeps a sliding boxcar average over the last 2^LOG2_N samples in a circular buffer, plus peak-hold min/max. It also runs a watchdog that flags a stalled sample stream, for example when ALERT/RDY stops toggling or the bus hangs. Its outputs feed display/UART formatting logic.

---
 rtl/adc_avg_filter.sv | 139 +++++++++++++
 tb/tb_adc_avg_filter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_avg_filter.sv
// Sliding boxcar average over the last 2^LOG2_N ADC samples, with peak-hold
// min/max, a dropped-strobe overrun flag and a stalled-stream watchdog.
module adc_avg_filter #(
    parameter int unsigned LOG2_N         = 4,
    parameter int unsigned TIMEOUT_CYCLES = 250_000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] i_data,
    input  logic        i_valid,
    input  logic        i_clear,
    output logic [15:0] o_avg,
    output logic        o_avg_valid,
    output logic [15:0] o_min,
    output logic [15:0] o_max,
    output logic        o_full,
    output logic        o_stale,
    output logic        o_overrun
);

    localparam int unsigned N   = 1 << LOG2_N;
    localparam int unsigned SW  = 16 + LOG2_N;
    localparam int unsigned WDW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [WDW-1:0]    WD_MAX   = WDW'(TIMEOUT_CYCLES);
    localparam logic [WDW-1:0]    WD_ONE   = 1;
    localparam logic [LOG2_N:0]   CNT_FULL = (LOG2_N + 1)'(N);
    localparam logic [LOG2_N:0]   CNT_ONE  = 1;
    localparam logic [LOG2_N-1:0] WPTR_ONE = 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_UPDATE,
        S_OUTPUT
    } state_t;

    state_t               state;
    logic [15:0]          win_buf [N];
    logic [LOG2_N-1:0]    wptr;
    logic [LOG2_N:0]      count;
    logic signed [SW-1:0] sum;
    logic signed [15:0]   sample;
    logic [WDW-1:0]       wd_cnt;

    logic                 window_full;
    logic [LOG2_N:0]      count_next;
    logic signed [SW-1:0] sample_ext;
    logic signed [SW-1:0] oldest_ext;

    // Buffer is never cleared; the fill count decides whether the oldest entry is live.
    always_comb begin
        window_full = (count == CNT_FULL);
        count_next  = window_full ? count : count + CNT_ONE;
        sample_ext  = {{LOG2_N{sample[15]}}, sample};
        oldest_ext  = '0;
        if (window_full) begin
            oldest_ext = {{LOG2_N{win_buf[wptr][15]}}, win_buf[wptr]};
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst && !i_clear && state == S_UPDATE) begin
            win_buf[wptr] <= sample;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= S_IDLE;
            wptr        <= '0;
            count       <= '0;
            sum         <= '0;
            sample      <= '0;
            wd_cnt      <= '0;
            o_avg       <= '0;
            o_avg_valid <= 1'b0;
            o_min       <= '0;
            o_max       <= '0;
            o_full      <= 1'b0;
            o_stale     <= 1'b0;
            o_overrun   <= 1'b0;
        end else if (i_clear) begin
            state       <= S_IDLE;
            wptr        <= '0;
            count       <= '0;
            sum         <= '0;
            wd_cnt      <= '0;
            o_avg_valid <= 1'b0;
            o_full      <= 1'b0;
            o_stale     <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            o_avg_valid <= 1'b0;
            o_stale     <= (wd_cnt == WD_MAX);

            if (i_valid && state == S_IDLE) begin
                wd_cnt <= '0;
            end else if (wd_cnt != WD_MAX) begin
                wd_cnt <= wd_cnt + WD_ONE;
            end

            if (i_valid && state != S_IDLE) begin
                o_overrun <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (i_valid) begin
                        sample <= i_data;
                        state  <= S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    sum    <= sum + sample_ext - oldest_ext;
                    wptr   <= wptr + WPTR_ONE;
                    count  <= count_next;
                    o_full <= (count_next == CNT_FULL);
                    if (count == '0) begin
                        o_min <= sample;
                        o_max <= sample;
                    end else begin
                        if (sample < $signed(o_min)) o_min <= sample;
                        if (sample > $signed(o_max)) o_max <= sample;
                    end
                    state <= S_OUTPUT;
                end
                S_OUTPUT: begin
                    if (o_full) begin
                        o_avg       <= 16'(sum >>> LOG2_N);
                        o_avg_valid <= 1'b1;
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_avg_filter.sv
// Self-checking bench for adc_avg_filter: queue-based window model checked every
// cycle, plus directed vectors with hand-computed expectations.
module tb_adc_avg_filter;

    localparam int unsigned LOG2_N = 4;
    localparam int          NWIN   = 16;
    localparam int          TO     = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] data;
    logic        valid;
    logic        clear;
    logic [15:0] o_avg;
    logic        o_avg_valid;
    logic [15:0] o_min;
    logic [15:0] o_max;
    logic        o_full;
    logic        o_stale;
    logic        o_overrun;

    always #5 clk = ~clk;

    adc_avg_filter #(
        .LOG2_N        (LOG2_N),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_data     (data),
        .i_valid    (valid),
        .i_clear    (clear),
        .o_avg      (o_avg),
        .o_avg_valid(o_avg_valid),
        .o_min      (o_min),
        .o_max      (o_max),
        .o_full     (o_full),
        .o_stale    (o_stale),
        .o_overrun  (o_overrun)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: window as a queue of accepted samples, expected outputs as plain values.
    int win[$];
    int m_avg, m_min, m_max;
    bit m_av, m_full, m_stale, m_ovr;
    int wd, busy, upd_s;
    bit upd_p, avg_p, live;

    function automatic int win_avg();
        int s = 0;
        int q;
        foreach (win[i]) s += win[i];
        q = s / NWIN;
        if (s < 0 && (s % NWIN) != 0) q -= 1;
        return q;
    endfunction

    always @(posedge clk) begin : model
        bit acc;
        if (rst) begin
            live = 1'b1;
            win.delete();
            m_avg = 0; m_min = 0; m_max = 0;
            m_av = 0; m_full = 0; m_stale = 0; m_ovr = 0;
            wd = 0; busy = 0; upd_p = 0; avg_p = 0;
        end else if (clear) begin
            win.delete();
            m_av = 0; m_full = 0; m_stale = 0; m_ovr = 0;
            wd = 0; busy = 0; upd_p = 0; avg_p = 0;
        end else begin
            m_av = 0;
            acc = valid && busy == 0;
            if (valid && busy != 0) m_ovr = 1;
            m_stale = (wd == TO);
            if (acc) wd = 0;
            else if (wd < TO) wd = wd + 1;
            if (avg_p) begin
                m_avg = win_avg();
                m_av  = 1;
                avg_p = 0;
            end
            if (upd_p) begin
                if (win.size() == 0) begin
                    m_min = upd_s;
                    m_max = upd_s;
                end else begin
                    if (upd_s < m_min) m_min = upd_s;
                    if (upd_s > m_max) m_max = upd_s;
                end
                win.push_back(upd_s);
                if (win.size() > NWIN) void'(win.pop_front());
                m_full = (win.size() == NWIN);
                if (m_full) avg_p = 1;
                upd_p = 0;
            end
            if (acc) begin
                upd_p = 1;
                upd_s = $signed(data);
                busy  = 2;
            end else if (busy > 0) begin
                busy = busy - 1;
            end
        end
    end

    always @(negedge clk) begin
        if (live) begin
            chk("avg",       o_avg,              16'(m_avg));
            chk("avg_valid", 16'(o_avg_valid),   16'(m_av));
            chk("min",       o_min,              16'(m_min));
            chk("max",       o_max,              16'(m_max));
            chk("full",      16'(o_full),        16'(m_full));
            chk("stale",     16'(o_stale),       16'(m_stale));
            chk("overrun",   16'(o_overrun),     16'(m_ovr));
        end
    end

    task automatic send(input logic [15:0] d);
        @(negedge clk);
        data  = d;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; valid = 1'b0; clear = 1'b0; data = '0;
        idle(3);
        chk("rst_avg",   o_avg, 16'h0000);
        chk("rst_min",   o_min, 16'h0000);
        chk("rst_max",   o_max, 16'h0000);
        chk("rst_full",  16'(o_full), 16'h0);
        chk("rst_stale", 16'(o_stale), 16'h0);
        chk("rst_ovr",   16'(o_overrun), 16'h0);
        rst = 1'b0;
        idle(2);

        // Fill: 16 x 1000
        for (int i = 0; i < 15; i++) begin
            send(16'd1000);
            idle(8);
        end
        chk("fill_not_full", 16'(o_full), 16'h0);
        send(16'd1000);
        idle(2);
        chk("fill_av",   16'(o_avg_valid), 16'h1);
        chk("fill_avg",  o_avg, 16'd1000);
        chk("fill_full", 16'(o_full), 16'h1);
        chk("fill_min",  o_min, 16'd1000);
        chk("fill_max",  o_max, 16'd1000);
        idle(1);
        chk("fill_pulse_one_cycle", 16'(o_avg_valid), 16'h0);
        idle(6);

        // Slide
        send(16'd2600);
        idle(2);
        chk("slide_avg", o_avg, 16'd1100);
        chk("slide_max", o_max, 16'd2600);
        chk("slide_min", o_min, 16'd1000);
        idle(6);
        for (int i = 0; i < 16; i++) begin
            send(16'd2600);
            idle(8);
        end
        chk("converge_avg", o_avg, 16'd2600);

        // Signed rounding
        do_clear();
        chk("clear_full", 16'(o_full), 16'h0);
        for (int i = 0; i < 16; i++) begin
            send(16'hFFFD);
            idle(8);
        end
        chk("neg3_avg", o_avg, 16'hFFFD);

        do_clear();
        for (int i = 0; i < 15; i++) begin
            send(16'hFFFF);
            idle(8);
        end
        send(16'h0000);
        idle(8);
        chk("floor_avg", o_avg, 16'hFFFF);

        do_clear();
        for (int i = 0; i < 16; i++) begin
            send(16'h7FFF);
            idle(8);
        end
        chk("maxpos_avg", o_avg, 16'h7FFF);

        do_clear();
        for (int i = 0; i < 16; i++) begin
            send(16'h8000);
            idle(8);
        end
        chk("maxneg_avg", o_avg, 16'h8000);
        chk("maxneg_min", o_min, 16'h8000);

        // Overrun: second strobe lands one cycle after the accepted one
        send(16'd500);
        data  = 16'd600;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        idle(1);
        chk("ovr_set",  16'(o_overrun), 16'h1);
        chk("ovr_max",  o_max, 16'd500);
        chk("ovr_full", 16'(o_full), 16'h1);
        idle(5);
        do_clear();
        chk("ovr_cleared",  16'(o_overrun), 16'h0);
        chk("full_cleared", 16'(o_full), 16'h0);
        send(16'd42);
        idle(1);
        chk("reload_min", o_min, 16'd42);
        chk("reload_max", o_max, 16'd42);

        // Watchdog
        idle(99);
        chk("stale_before", 16'(o_stale), 16'h0);
        idle(1);
        chk("stale_rise", 16'(o_stale), 16'h1);
        send(16'd43);
        chk("stale_hold_at_accept", 16'(o_stale), 16'h1);
        idle(1);
        chk("stale_fall", 16'(o_stale), 16'h0);
        idle(6);

        // Reset the cycle after an accept that would complete a window
        for (int i = 0; i < 14; i++) begin
            send(16'd10);
            idle(8);
        end
        send(16'd77);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle(1);
        chk("rstmid_av",   16'(o_avg_valid), 16'h0);
        chk("rstmid_avg",  o_avg, 16'h0000);
        chk("rstmid_min",  o_min, 16'h0000);
        chk("rstmid_max",  o_max, 16'h0000);
        chk("rstmid_full", 16'(o_full), 16'h0);

        // Clear coincident with valid
        idle(2);
        @(negedge clk);
        data  = 16'd99;
        valid = 1'b1;
        clear = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        clear = 1'b0;
        idle(2);
        chk("clrv_ovr", 16'(o_overrun), 16'h0);
        chk("clrv_min", o_min, 16'h0000);
        send(16'd7);
        idle(1);
        chk("clrv_next_min", o_min, 16'd7);
        chk("clrv_next_max", o_max, 16'd7);
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
